// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write arbiter and the FIFO write port.
// master: the arbiter side; slave: the producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int OCW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_data;
    logic               fifo_pop;
    logic               fifo_full;
    logic [OCW-1:0]     occ;
    logic               ovf_err;

    modport master (
        input  req, req_data, fifo_pop, fifo_full,
        output gnt, fifo_wr_en, fifo_data, occ, ovf_err
    );

    modport slave (
        output req, req_data, fifo_pop, fifo_full,
        input  gnt, fifo_wr_en, fifo_data, occ, ovf_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Credit-based round-robin write arbiter feeding a small FIFO through a registered write stage.
// Optional macro FIFO_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fifo_wr_arbiter_if.master bus
);
    localparam int PW  = $clog2(NREQ);
    localparam int OCW = $clog2(DEPTH + 1);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [OCW-1:0]  occ_q, occ_d;
    logic            wr_en_q, wr_en_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ovf_q, ovf_d;

    logic [NREQ-1:0] rr_req_s;
    logic [NREQ-1:0] gnt_s;
    logic [PW-1:0]   rr_win_s;
    logic [PW-1:0]   win_s;
    logic            rr_found_s;
    logic            prio0_s;
    logic            found_s;
    logic            accept_s;

    // Winner selection: scan from ptr+1 upward, wrapping; gated by registered credit only.
    always_comb begin
        int  idx_v;
        logic take_v;
        idx_v      = 0;
        take_v     = 1'b0;
`ifdef FIFO_ARB_PRIO0_EN
        prio0_s    = bus.req[0];
        rr_req_s   = bus.req & ~{{(NREQ-1){1'b0}}, 1'b1};
`else
        prio0_s    = 1'b0;
        rr_req_s   = bus.req;
`endif
        rr_win_s   = '0;
        rr_found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v      = (int'(ptr_q) + k) % NREQ;
            take_v     = rr_req_s[idx_v] & ~rr_found_s;
            rr_win_s   = take_v ? PW'(idx_v) : rr_win_s;
            rr_found_s = rr_found_s | take_v;
        end
        win_s    = prio0_s ? '0 : rr_win_s;
        found_s  = prio0_s | rr_found_s;
        accept_s = !rst_i && (occ_q < OCW'(DEPTH)) && found_s;
        gnt_s    = accept_s ? (NREQ'(1'b1) << win_s) : '0;
    end

    // Next-state for write stage, pointer, credit counter and sticky overflow flag.
    always_comb begin
        wr_en_d = accept_s;
        data_d  = accept_s ? bus.req_data[win_s*DW +: DW] : data_q;
        ptr_d   = (accept_s && !prio0_s) ? win_s : ptr_q;
        ovf_d   = ovf_q | (wr_en_q & bus.fifo_full);
        // Accept and pop together cancel; saturate so occ never wraps.
        case ({accept_s, bus.fifo_pop})
            2'b10:   occ_d = occ_q + OCW'(1);
            2'b01:   occ_d = (occ_q == '0) ? occ_q : occ_q - OCW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= PW'(NREQ - 1);
            occ_q   <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.gnt        = gnt_s;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_data  = data_q;
    assign bus.occ        = occ_q;
    assign bus.ovf_err    = ovf_q;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 4-entry, 8-bit `fifo` among `NREQ` independent producers. It picks at most one requester per cycle and forwards that word to the FIFO through a registered write stage. It tracks FIFO occupancy with an internal credit counter, so it never issues a write that would overflow. It sits directly in front of `fifo` (`fifo_wr_en` → `wr_en`, `fifo_data` → `data_in`).

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `DW`, 8, data width; must match the FIFO.
- `DEPTH`, 4, FIFO capacity in words; credit limit.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset. Synchronous, active-high (one clock; reset is synchronous and active-high).
- `req`  in  NREQ  per-requester "word valid".
- `req_data`  in  NREQ*DW  packed words; requester i uses bits [i*DW +: DW].
- `gnt`  out  NREQ  one-hot combinational grant; transfer of requester i when `req[i] & gnt[i]` at a rising edge.
- `fifo_wr_en`  out  1  registered write strobe to the FIFO.
- `fifo_data`  out  DW  registered write data.
- `fifo_pop`  in  1  FIFO read accepted this cycle (`rd_en & !empty`).
- `fifo_full`  in  1  FIFO full flag; used for checking only.
- `occ`  out  $clog2(DEPTH+1)  credit counter: words written or in flight, not yet popped.
- `ovf_err`  out  1  sticky error.

## Operation
- State: `occ`, last-winner pointer `ptr` ($clog2(NREQ) bits), output register (`fifo_wr_en`, `fifo_data`), `ovf_err`.
- Accept condition: `!rst && occ < DEPTH && |req`. When it is false, `gnt` = 0.
- Winner selection: the first set `req` bit scanning `ptr+1, ptr+2, …` modulo NREQ. `gnt` is one-hot for the winner.
- On an accepting edge:
  - `fifo_wr_en` ← 1, `fifo_data` ← winner's word, `ptr` ← winner index.
  - On other edges, `fifo_wr_en` ← 0 and `fifo_data` holds its value.
- Credit update each edge: `occ` ← `occ + accept − fifo_pop`. Simultaneous accept and pop leaves `occ` unchanged. `occ` never wraps.
- Accept is based on the registered `occ` only. No same-cycle bypass on pop: at `occ == DEPTH`, a pop frees the credit one cycle later.
- `gnt` has no combinational path from `fifo_pop` or `fifo_full`.
- A requester holding `req` keeps its data stable until granted. A requester never gets two consecutive grants while another requester is waiting.
- `ovf_err` ← 1 when `fifo_wr_en & fifo_full` at an edge. It stays set until reset.
- Reset:
  - `gnt` = 0 while `rst` is high.
  - `fifo_wr_en` = 0, `fifo_data` = 0, `occ` = 0, `ptr` = NREQ−1 (requester 0 wins first), `ovf_err` = 0.
  - Reset mid-operation drops any in-flight word. The FIFO must be reset in the same cycle.

## Timing
- Accept at edge E → `fifo_wr_en`/`fifo_data` valid in cycle E..E+1 → FIFO stores the word at edge E+1.
- Sustained throughput: 1 word/cycle while `occ < DEPTH`.
- Grant latency: same cycle as `req` when credits are available.
- Worst-case wait for a requester with no priority override: NREQ−1 grants.
- Pop at edge P → `occ` decrements at P → new accept possible in cycle P..P+1.
- Reset release: first accept can happen in the first cycle with `rst` low.

## Configuration
- `FIFO_ARB_PRIO0_EN` defined:
  - Requester 0 has strict priority: if `req[0]` is set and credits are available, `gnt[0]` wins regardless of `ptr`.
  - `ptr` is not updated on requester-0 grants.
  - Requesters 1..NREQ−1 round-robin among themselves.
- Not defined: pure round-robin over all NREQ requesters as described above.

## Test plan
- Reset, then `req`=4'b1111 held with data 8'hA0+i, `fifo_pop`=0. Expected: grants 0,1,2,3 on consecutive cycles; FIFO holds A0,A1,A2,A3; `occ`=4; `gnt`=0 afterwards; `ovf_err`=0.
- FIFO full (`occ`=4), assert `fifo_pop` for one cycle with `req`=4'b0100. Expected: `occ`→3, then `gnt`=4'b0100 one cycle later, `occ`→4.
- Simultaneous accept and pop at `occ`=2. Expected: `occ` stays 2 and the written word appears on `fifo_data` the next cycle.
- `req`=4'b1001 held, `fifo_pop` every cycle. Expected: strictly alternating grants 0,3,0,3. With `FIFO_ARB_PRIO0_EN`: grant 0 every cycle and requester 3 starves.
- Assert `rst` for one cycle while `occ`=3 and `fifo_wr_en`=1. Expected: next cycle `fifo_wr_en`=0, `fifo_data`=0, `occ`=0, `gnt`=0 during reset; the first grant after release goes to requester 0.
- Force `fifo_full`=1 while `fifo_wr_en`=1. Expected: `ovf_err`=1 on the next cycle and it stays set until `rst`.
